// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the accumulator datapath controller and its ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, op codes, ALU function codes.
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_INC  = 2'd1;
  localparam logic [1:0] OP_ROT  = 2'd2;
  localparam logic [1:0] OP_QLD  = 2'd3;

  // ALU function codes, shared with the datapath ALU.
  localparam logic [2:0] ALU_OP_ADD    = 3'd0;
  localparam logic [2:0] ALU_OP_SUB    = 3'd1;
  localparam logic [2:0] ALU_OP_AND    = 3'd2;
  localparam logic [2:0] ALU_OP_OR     = 3'd3;
  localparam logic [2:0] ALU_OP_XOR    = 3'd4;
  localparam logic [2:0] ALU_OP_PASS_A = 3'd5;
  localparam logic [2:0] ALU_OP_PASS_B = 3'd6;
  localparam logic [2:0] ALU_OP_NOT    = 3'd7;

  function automatic logic is_active(input state_t s);
    return (s == ST_LOAD) || (s == ST_SHIFT) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Request/response and datapath-control bundle of the datapath controller.
// Latency: n/a (wires only).
// Backpressure: start is honoured only while busy is low; no queueing.
// master = system sequencer side (drives start/op/count/q_dir[/abort]),
// slave = controller side (drives busy/done and all datapath controls).
// The abort line exists only when DATAPATH_CTRL_ABORT_EN is defined.
interface datapath_ctrl_if #(parameter int CNT_W = 2);
  import datapath_ctrl_pkg::*;

  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic             q_dir;
`ifdef DATAPATH_CTRL_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             done;
  logic             mux_2x1_R1_sel;
  logic             mux_2x1_alu_a_sel;
  logic             mux_2x1_acc_sel;
  logic             acc_load_sel;
  logic             q_dir_sel;
  logic [2:0]       alu_control;

`ifdef DATAPATH_CTRL_ABORT_EN
  modport master (
    output start, op, count, q_dir, abort,
    input  busy, done, mux_2x1_R1_sel, mux_2x1_alu_a_sel, mux_2x1_acc_sel,
           acc_load_sel, q_dir_sel, alu_control
  );
  modport slave (
    input  start, op, count, q_dir, abort,
    output busy, done, mux_2x1_R1_sel, mux_2x1_alu_a_sel, mux_2x1_acc_sel,
           acc_load_sel, q_dir_sel, alu_control
  );
`else
  modport master (
    output start, op, count, q_dir,
    input  busy, done, mux_2x1_R1_sel, mux_2x1_alu_a_sel, mux_2x1_acc_sel,
           acc_load_sel, q_dir_sel, alu_control
  );
  modport slave (
    input  start, op, count, q_dir,
    output busy, done, mux_2x1_R1_sel, mux_2x1_alu_a_sel, mux_2x1_acc_sel,
           acc_load_sel, q_dir_sel, alu_control
  );
`endif

endinterface

// File: rtl/datapath_ctrl_shift_cnt.sv
// Loadable down-counter that paces the rotate steps of the controller.
// Latency: load/decrement visible one cycle after the edge.
// Backpressure: none; load has priority over decrement.
// Ports: clk, reset (async active-low), load/load_val, dec, cnt, zero.
module dp_shift_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/datapath_ctrl.sv
// Sequencing controller for the 4-bit accumulator datapath (load, rotate, write R1).
// Latency: start to done 3 cycles, or 3+count for a rotate.
// Backpressure: start is accepted only while busy is low (IDLE or DONE); ignored otherwise.
// Ports: clk, reset (async active-low), ctrl (datapath_ctrl_if.slave: start/op/count/q_dir
// in, busy/done and datapath control lines out).
// Optional: DATAPATH_CTRL_ABORT_EN adds ctrl.abort, which returns an active op to IDLE.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  datapath_ctrl_if.slave  ctrl
);

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic             q_dir_q;
  logic             accept;
  logic             abort_req;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             cnt_one;

  assign accept = ctrl.start && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef DATAPATH_CTRL_ABORT_EN
  assign abort_req = ctrl.abort && is_active(state);
`else
  assign abort_req = 1'b0;
`endif

  // Loaded with the requested count at acceptance so LOAD can already see
  // whether any rotate steps are needed.
  dp_shift_cnt #(.CNT_W(CNT_W)) u_shift_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (ctrl.count),
    .dec      (state == ST_SHIFT),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  assign cnt_one = (cnt_val == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      op_q    <= OP_PASS;
      q_dir_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= ctrl.op;
        q_dir_q <= ctrl.q_dir;
      end
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE,
      ST_DONE:  state_nxt = accept ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_nxt = ((op_q == OP_ROT) && !cnt_zero) ? ST_SHIFT : ST_WRITE;
      // Leave on the edge where the last step is taken (counter reads 1).
      ST_SHIFT: state_nxt = cnt_one ? ST_WRITE : ST_SHIFT;
      ST_WRITE: state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_req) begin
      state_nxt = ST_IDLE;
    end
  end

  // Moore decode; every line starts from its IDLE value.
  always_comb begin
    ctrl.busy              = is_active(state);
    ctrl.done              = (state == ST_DONE);
    ctrl.acc_load_sel      = 1'b1;
    ctrl.mux_2x1_acc_sel   = 1'b0;
    ctrl.mux_2x1_alu_a_sel = 1'b0;
    ctrl.mux_2x1_R1_sel    = 1'b0;
    ctrl.alu_control       = ALU_OP_ADD;
    ctrl.q_dir_sel         = q_dir_q;
    case (state)
      ST_LOAD: begin
        ctrl.mux_2x1_alu_a_sel = (op_q == OP_INC);
        ctrl.mux_2x1_acc_sel   = (op_q == OP_QLD);
      end
      ST_SHIFT: ctrl.acc_load_sel = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl with a behavioural 4-bit datapath and scoreboard.
// Latency: n/a.
// Backpressure: driver waits for busy low before each request.
module tb_datapath_ctrl;
  import datapath_ctrl_pkg::*;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  datapath_ctrl_if #(.CNT_W(CNT_W)) dif ();
  datapath_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .ctrl(dif));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural datapath driven by the controller's lines.
  logic [3:0] din = 4'h0, q_d = 4'h0;
  logic [3:0] r0 = 4'h0, acc = 4'h0, r1 = 4'h0;

  function automatic logic [3:0] dp_alu(input logic [2:0] f, input logic a_sel, input logic [3:0] b);
    if (f != ALU_OP_ADD) return 4'h0;
    return (a_sel ? 4'h1 : 4'h0) + b;
  endfunction

  always @(posedge clk) begin
    r0  <= din;
    if (dif.acc_load_sel)
      acc <= dif.mux_2x1_acc_sel ? q_d : dp_alu(dif.alu_control, dif.mux_2x1_alu_a_sel, r0);
    else
      acc <= {acc[2:0], acc[3]};
    r1  <= dif.mux_2x1_R1_sel ? r0 : acc;
  end

  // Reference: result of an op, straight from the op definitions.
  function automatic int ref_model(input int op, input int x, input int q, input int k);
    int y;
    case (op)
      0: return x;
      1: return (x + 1) % 16;
      2: begin
        y = x;
        for (int i = 0; i < k; i++) y = (y * 2) % 16 + y / 8;
        return y;
      end
      default: return q;
    endcase
  endfunction

  typedef struct {
    int e0;       // cycle number of LOAD
    int out;
    int lat;
    int shifts;
    int a_sel;
    int acc_sel;
    int qd;
  } exp_t;
  exp_t sb[$];

  // Monitor: compares whenever the DUT presents done, plus LOAD-cycle controls.
  int shifts = 0;
  exp_t h;
  always @(negedge clk) begin
    if (!reset) begin
      shifts = 0;
    end else begin
      if (sb.size() > 0) begin
        h = sb[0];
        if (cyc == h.e0) begin
          chk("load_busy", int'(dif.busy), 1);
          chk("load_alu_a_sel", int'(dif.mux_2x1_alu_a_sel), h.a_sel);
          chk("load_acc_sel", int'(dif.mux_2x1_acc_sel), h.acc_sel);
          chk("load_acc_load_sel", int'(dif.acc_load_sel), 1);
          shifts = 0;
        end else if (cyc > h.e0 && !dif.acc_load_sel) begin
          shifts++;
        end
      end
      if (dif.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          h = sb.pop_front();
          chk("latency", cyc - h.e0 + 1, h.lat);
          chk("out_r1", int'(r1), h.out);
          chk("rotate_cycles", shifts, h.shifts);
          chk("q_dir_sel", int'(dif.q_dir_sel), h.qd);
        end
      end else if (sb.size() > 0 && cyc > sb[0].e0 + sb[0].lat - 1) begin
        chk("done_timeout", cyc - sb[0].e0 + 1, sb[0].lat);
        void'(sb.pop_front());
      end
    end
  end

  task automatic set_req(input int op, input int x, input int k, input int qd, input int qv);
    din       = 4'(x);
    q_d       = 4'(qv);
    dif.op    = 2'(op);
    dif.count = CNT_W'(k);
    dif.q_dir = 1'(qd);
    dif.start = 1'b1;
  endtask

  task automatic push_exp(input int op, input int x, input int k, input int qd, input int qv);
    exp_t e;
    int n;
    n = (op == 2) ? k : 0;
    e.e0 = cyc + 1;
    e.out = ref_model(op, x, qv, n);
    e.lat = 3 + n;
    e.shifts = n;
    e.a_sel = (op == 1) ? 1 : 0;
    e.acc_sel = (op == 3) ? 1 : 0;
    e.qd = qd;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns in LOAD+1 with start low.
  task automatic issue(input int op, input int x, input int k, input int qd, input int qv);
    set_req(op, x, k, qd, qv);
    push_exp(op, x, k, qd, qv);
    @(posedge clk) #1;
    dif.start = 1'b0;
    @(posedge clk) #1;
    din = 4'($urandom);
    q_d = 4'($urandom);
  endtask

  // Wait for busy low; pokes ignored starts with junk while busy.
  task automatic wait_idle(input bit poke);
    int t;
    t = 0;
    while (dif.busy && t < 60) begin
      dif.start = poke ? 1'($urandom) : 1'b0;
      dif.op    = 2'($urandom);
      dif.count = CNT_W'($urandom);
      dif.q_dir = 1'($urandom);
      @(posedge clk) #1;
      t++;
    end
    dif.start = 1'b0;
    if (t >= 60) chk("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    int op, k, gap;
    dif.start = 1'b1;
    dif.op    = OP_PASS;
    dif.count = '0;
    dif.q_dir = 1'b1;
`ifdef DATAPATH_CTRL_ABORT_EN
    dif.abort = 1'b0;
`endif

    // Reset held with start high: IDLE values throughout.
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(dif.busy), 0);
    chk("rst_done", int'(dif.done), 0);
    chk("rst_acc_load_sel", int'(dif.acc_load_sel), 1);
    chk("rst_acc_sel", int'(dif.mux_2x1_acc_sel), 0);
    chk("rst_alu_a_sel", int'(dif.mux_2x1_alu_a_sel), 0);
    chk("rst_r1_sel", int'(dif.mux_2x1_R1_sel), 0);
    chk("rst_alu_control", int'(dif.alu_control), int'(ALU_OP_ADD));
    chk("rst_q_dir_sel", int'(dif.q_dir_sel), 0);

    // Release with start still high: first op accepted on the next edge.
    @(posedge clk) #1;
    set_req(0, 4'h6, 0, 1, 0);
    push_exp(0, 4'h6, 0, 1, 0);
    reset = 1'b1;
    @(posedge clk) #1;
    dif.start = 1'b0;
    @(posedge clk) #1;

    // Directed cases, back-to-back when the bench lands in DONE.
    wait_idle(0); issue(0, 4'h9, 0, 0, 4'h3);
    wait_idle(0); issue(1, 4'hF, 0, 1, 4'h3);
    wait_idle(0); issue(2, 4'h1, 3, 0, 4'h3);
    wait_idle(0); issue(2, 4'h5, 0, 1, 4'h3);
    wait_idle(1); issue(3, 4'h2, 2, 0, 4'hB);
    wait_idle(1); issue(2, 4'h8, 1, 1, 4'h0);

    // Async reset in the middle of a rotate.
    wait_idle(0);
    set_req(2, 4'h5, 3, 1, 0);
    @(posedge clk) #1;
    dif.start = 1'b0;
    @(posedge clk) #1;
    chk("shift_before_reset", int'(dif.acc_load_sel), 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", int'(dif.busy), 0);
    chk("midrst_done", int'(dif.done), 0);
    chk("midrst_acc_load_sel", int'(dif.acc_load_sel), 1);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", int'(dif.done), 0);
    end
    @(posedge clk) #1;
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", int'(dif.busy | dif.done), 0);
    end

`ifdef DATAPATH_CTRL_ABORT_EN
    // Abort during SHIFT: back to IDLE, no done.
    @(posedge clk) #1;
    set_req(2, 4'h3, 3, 0, 0);
    @(posedge clk) #1;
    dif.start = 1'b0;
    @(posedge clk) #1;
    dif.abort = 1'b1;
    @(posedge clk) #1;
    dif.abort = 1'b0;
    chk("abort_busy", int'(dif.busy), 0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", int'(dif.done), 0);
    end
    // Abort while IDLE is ignored.
    @(posedge clk) #1;
    dif.abort = 1'b1;
    set_req(1, 4'h7, 0, 1, 0);
    push_exp(1, 4'h7, 0, 1, 0);
    @(posedge clk) #1;
    dif.start = 1'b0;
    dif.abort = 1'b0;
    @(posedge clk) #1;
`endif

    // Randomized traffic.
    @(posedge clk) #1;
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk) #1;
      wait_idle($urandom_range(0, 1) == 1);
      op = $urandom_range(0, 3);
      k  = $urandom_range(0, 3);
      issue(op, $urandom_range(0, 15), k, $urandom_range(0, 1), $urandom_range(0, 15));
    end

    begin
      int t;
      t = 0;
      while (sb.size() > 0 && t < 100) begin
        @(posedge clk) #1;
        t++;
      end
      if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
    end
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Sequencing controller for the 4-bit accumulator datapath (R0/R1 registers, rotating accumulator, Q shift register, ALU, three 2:1 selects). It accepts one operation per start/done handshake and drives every datapath control line cycle by cycle. The sequence loads the accumulator, optionally rotates it, and transfers the result to R1. It sits between the system sequencer and the datapath and is the only driver of the datapath control pins.

## Interface
- Parameter `CNT_W`, default 2. Width of the rotate-count field.
- `clk` — input, 1 — rising-edge clock.
- `reset` — input, 1 — asynchronous, active-low reset.
- `start` — input, 1 — request. Sampled only when `busy`=0.
- `op` — input, 2 — operation code. Sampled with `start`.
- `count` — input, `CNT_W` — number of rotate steps for the ROT operation. Sampled with `start`.
- `q_dir` — input, 1 — Q shift direction. Sampled with `start`.
- `busy` — output, 1 — operation in progress.
- `done` — output, 1 — one-cycle pulse. Datapath `out` (R1) holds the result in this cycle.
- `mux_2x1_R1_sel`, `mux_2x1_alu_a_sel`, `mux_2x1_acc_sel`, `acc_load_sel`, `q_dir_sel` — outputs, 1 each — datapath controls.
- `alu_control` — output, 3 — ALU function.

## Operation
- Op codes:
  - OP_PASS=0: acc←0+R0.
  - OP_INC=1: acc←1+R0.
  - OP_ROT=2: acc←R0, then `count` rotate steps.
  - OP_QLD=3: acc←Q.
- Every op ends with R1←acc.
- FSM states: IDLE, LOAD, SHIFT, WRITE, DONE.
  - IDLE/DONE: `start`=1 latches `op`, `count` and `q_dir`, then → LOAD.
  - LOAD → SHIFT if op=ROT and count≠0, else → WRITE.
  - SHIFT: down-counter decrements once per cycle; → WRITE when it reaches 1 at the clock edge.
  - WRITE → DONE.
  - DONE → IDLE, or → LOAD if `start`=1 (back-to-back).
- Moore outputs, decoded from the registered state and the latched op:
  - IDLE/DONE: acc_load_sel=1, acc_sel=0, alu_a_sel=0, R1_sel=0, alu_control=ALU_OP_ADD.
  - LOAD: acc_load_sel=1, alu_control=ALU_OP_ADD.
    - alu_a_sel=1 for OP_INC, else 0.
    - acc_sel=1 for OP_QLD, else 0.
  - SHIFT: acc_load_sel=0 (rotate); other lines hold their IDLE values.
  - WRITE: R1_sel=0 (R1←acc at the edge); acc_load_sel=1.
  - q_dir_sel = latched `q_dir` in all states; 0 after reset.
- `busy`=1 in LOAD, SHIFT and WRITE. `done`=1 only in DONE.
- `start` while `busy`=1 is ignored; no queueing.
- Caller holds `in` stable from the `start` cycle through LOAD, because R0 reloads every cycle.
- Arithmetic is 4-bit and wraps (0xF+1=0x0). The controller performs no arithmetic of its own.
- Illegal or unreachable state → IDLE on the next edge.

## Timing
- Reset (asynchronous, active-low): state=IDLE, counter=0, latched op/q_dir=0, busy=0, done=0, control outputs at IDLE values.
- Reset asserted mid-operation aborts immediately; no `done` is produced.
- `start` accepted at edge E0.
  - LOAD in cycle 1.
  - SHIFT in cycles 2..count+1 (ROT only).
  - WRITE in cycle 2+n, where n = count for ROT and 0 for all other ops.
  - DONE in cycle 3+n.
- Latency from `start` to `done`: 3 cycles, or 3+count for ROT.
- OP_ROT with count=0 behaves exactly like OP_PASS.
- Back-to-back issue: a new operation every 3+n cycles. `start` in the DONE cycle gives LOAD in the next cycle.

## Configuration
- `DATAPATH_CTRL_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 in LOAD, SHIFT or WRITE → IDLE at the next edge. No `done`; `busy` drops in the following cycle.
  - `abort` in IDLE or DONE has no effect.
- Undefined: no `abort` port; operations always run to completion.

## Structure
- Package `datapath_ctrl_pkg` holds:
  - state encoding;
  - op codes OP_PASS, OP_INC, OP_ROT, OP_QLD;
  - ALU function constants (ALU_OP_ADD and the rest), shared with the ALU.
- One sub-module `dp_shift_cnt`: loadable `CNT_W`-bit down-counter with a zero flag, used by the SHIFT state.

## Test plan
- Reset with `start` held high:
  - While reset is asserted, outputs hold their reset values and `busy`=0.
  - After release, the first `start` gives `done` 3 cycles later.
- OP_PASS, in=0x9 → LOAD has alu_a_sel=0 and acc_load_sel=1; `done` in cycle 3 with out=0x9.
- OP_INC, in=0xF → alu_a_sel=1 in LOAD; out=0x0 at `done` (wrap).
- OP_ROT, in=0x1, count=3:
  - acc_load_sel=0 for exactly 3 cycles;
  - `done` in cycle 6;
  - out equals 0x1 rotated 3 steps.
  - count=0 gives `done` in cycle 3.
- `start` during `busy` → ignored. `start` in the DONE cycle → LOAD in the next cycle and a second `done` 3 cycles later.
- Async reset asserted in SHIFT → immediate IDLE, `busy`=0, no `done`.
  - With `DATAPATH_CTRL_ABORT_EN`: `abort` in SHIFT → IDLE at the next edge, no `done`.
